// File: rtl/barrel_left_sat_if.sv
// Purpose: bundles the sample input and result output of barrel_left_sat.
// Latency: none (wiring only).
// Backpressure: none; the pipeline advances only on the global enable.
// Ports: master drives in_valid/is_signed/saturate/shift/in/ex and receives
//        out_valid/out/overflow; slave (the shifter) is the mirror image.
interface barrel_left_sat_if #(
  parameter int WIDTH       = 64,
  parameter int SHIFT_WIDTH = 6
);
  logic                   in_valid;
  logic                   is_signed;
  logic                   saturate;
  logic [SHIFT_WIDTH-1:0] shift;
  logic [WIDTH-1:0]       in;
  logic [WIDTH-1:0]       ex;
  logic                   out_valid;
  logic [WIDTH-1:0]       out;
  logic                   overflow;

  modport master (
    output in_valid, is_signed, saturate, shift, in, ex,
    input  out_valid, out, overflow
  );

  modport slave (
    input  in_valid, is_signed, saturate, shift, in, ex,
    output out_valid, out, overflow
  );
endinterface

// File: rtl/barrel_left_sat.sv
// Purpose: pipelined logarithmic left shifter with overflow detection and optional saturation.
// Latency: IS_REG_IN + SHIFT_WIDTH + 1 enable-high cycles; one sample per enable-high cycle.
// Backpressure: none internally; enable low freezes every register, valids included.
// Ports: clk, srst (sync active-high), enable (global advance), bus (slave modport):
//        in_valid/is_signed/saturate/shift/in/ex in, out_valid/out/overflow out.
module barrel_left_sat #(
  parameter int WIDTH       = 64,
  parameter int SHIFT_MAX   = 46,
  parameter int SHIFT_WIDTH = $clog2(SHIFT_MAX + 2),
  parameter int IS_REG_IN   = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  barrel_left_sat_if.slave bus
);

  // Elaboration-time parameter sanity: a too-narrow shift port would make
  // the out-of-range substitution unreachable and the ex path meaningless.
  if (SHIFT_WIDTH < $clog2(SHIFT_MAX + 2)) begin : g_bad_shift_width
    $fatal(1, "barrel_left_sat: SHIFT_WIDTH=%0d too small for SHIFT_MAX=%0d",
           SHIFT_WIDTH, SHIFT_MAX);
  end
  if (SHIFT_MAX < 1 || SHIFT_MAX > WIDTH - 1) begin : g_bad_shift_max
    $fatal(1, "barrel_left_sat: SHIFT_MAX=%0d outside 1..WIDTH-1", SHIFT_MAX);
  end

  // Everything a sample needs travels together so stages stay independent.
  typedef struct packed {
    logic                   valid;
    logic                   is_signed;
    logic                   saturate;
    logic                   oor;       // shift > SHIFT_MAX: result is ex
    logic                   sign;      // original operand MSB
    logic                   ovf;       // sticky overflow from shifted-out bits
    logic [SHIFT_WIDTH-1:0] shift;
    logic [WIDTH-1:0]       ex;
    logic [WIDTH-1:0]       data;
  } smp_t;

  smp_t in_smp;
  smp_t entry;
  smp_t sh_d [SHIFT_WIDTH];
  smp_t sh_q [SHIFT_WIDTH];

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_d, out_q;
  logic             overflow_d, overflow_q;

  always_comb begin
    in_smp           = '0;
    in_smp.valid     = bus.in_valid;
    in_smp.is_signed = bus.is_signed;
    in_smp.saturate  = bus.saturate;
    in_smp.oor       = (bus.shift > SHIFT_WIDTH'(SHIFT_MAX));
    in_smp.sign      = bus.in[WIDTH-1];
    in_smp.ovf       = 1'b0;
    in_smp.shift     = bus.shift;
    in_smp.ex        = bus.ex;
    in_smp.data      = bus.in;
  end

  if (IS_REG_IN != 0) begin : g_in_reg
    smp_t in_d, in_q;

    always_comb begin
      in_d = in_smp;
    end

    always_ff @(posedge clk) begin
      if (srst) begin
        in_q <= '0;
      end else if (enable) begin
        in_q <= in_d;
      end
    end

    always_comb begin
      entry = in_q;
    end
  end else begin : g_in_comb
    always_comb begin
      entry = in_smp;
    end
  end

  // One logarithmic stage: shift by 2^k when shift bit k is set. The bits
  // leaving the top are compared against zero (unsigned) or against the
  // original sign (signed); any mismatch sets the sticky overflow.
  function automatic smp_t stage_fn(input smp_t s, input int k);
    smp_t             r;
    logic [WIDTH-1:0] lost_mask;
    logic [WIDTH-1:0] diff;
    r = s;
    if (s.shift[k]) begin
      if ((1 << k) >= WIDTH) begin
        lost_mask = '1;
        r.data    = '0;
      end else begin
        lost_mask = ~({WIDTH{1'b1}} >> (1 << k));
        r.data    = s.data << (1 << k);
      end
      diff  = s.is_signed ? (s.data ^ {WIDTH{s.sign}}) : s.data;
      r.ovf = s.ovf | (|(diff & lost_mask));
    end
    return r;
  endfunction

  always_comb begin
    sh_d[0] = stage_fn(entry, 0);
    for (int k = 1; k < SHIFT_WIDTH; k++) begin
      sh_d[k] = stage_fn(sh_q[k-1], k);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int k = 0; k < SHIFT_WIDTH; k++) begin
        sh_q[k] <= '0;
      end
    end else if (enable) begin
      for (int k = 0; k < SHIFT_WIDTH; k++) begin
        sh_q[k] <= sh_d[k];
      end
    end
  end

  // Final stage: a signed result whose MSB no longer matches the original
  // sign is also an overflow, even if every shifted-out bit matched.
  always_comb begin
    smp_t last;
    logic ovf_raw;
    last        = sh_q[SHIFT_WIDTH-1];
    ovf_raw     = last.ovf | (last.is_signed & (last.data[WIDTH-1] ^ last.sign));
    out_valid_d = last.valid;
    out_d       = last.data;
    overflow_d  = ovf_raw;
    if (last.oor) begin
      out_d      = last.ex;
      overflow_d = 1'b0;
    end else if (last.saturate && ovf_raw) begin
      if (!last.is_signed) begin
        out_d = '1;
      end else if (last.sign) begin
        out_d = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        out_d = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      overflow_q  <= 1'b0;
    end else if (enable) begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_barrel_left_sat.sv
// Purpose: self-checking bench for barrel_left_sat (WIDTH=8, SHIFT_MAX=6, SHIFT_WIDTH=3).
// Latency: expected results travel through a 5-deep reference delay line.
// Backpressure: enable is toggled by the stimulus to exercise freezing.
module tb_barrel_left_sat;
  localparam int W   = 8;
  localparam int SM  = 6;
  localparam int SW  = 3;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic srst;
  logic enable;

  barrel_left_sat_if #(.WIDTH(W), .SHIFT_WIDTH(SW)) bus ();

  barrel_left_sat #(
    .WIDTH(W), .SHIFT_MAX(SM), .SHIFT_WIDTH(SW), .IS_REG_IN(1)
  ) dut (
    .clk   (clk),
    .srst  (srst),
    .enable(enable),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_emit = 0;

  logic       m_v [LAT];
  logic [7:0] m_o [LAT];
  logic       m_f [LAT];
  logic [7:0] cur_o;
  logic       cur_f;

  typedef struct packed {
    logic       sg;
    logic       sat;
    logic [2:0] sh;
    logic [7:0] i;
    logic [7:0] e;
    logic [7:0] eo;
    logic       ef;
  } vec_t;

  // Directed vectors with hand-derived expected results.
  vec_t dir [15] = '{
    '{1'b0, 1'b0, 3'd3, 8'h0F, 8'h00, 8'h78, 1'b0},
    '{1'b0, 1'b0, 3'd5, 8'h0F, 8'h00, 8'hE0, 1'b1},
    '{1'b0, 1'b1, 3'd5, 8'h0F, 8'h00, 8'hFF, 1'b1},
    '{1'b1, 1'b0, 3'd3, 8'hF0, 8'h00, 8'h80, 1'b0},
    '{1'b1, 1'b1, 3'd2, 8'h20, 8'h00, 8'h7F, 1'b1},
    '{1'b1, 1'b1, 3'd2, 8'hC0, 8'h00, 8'h80, 1'b1},
    '{1'b1, 1'b1, 3'd7, 8'hFF, 8'hA5, 8'hA5, 1'b0},
    '{1'b0, 1'b1, 3'd0, 8'hFF, 8'h00, 8'hFF, 1'b0},
    '{1'b1, 1'b1, 3'd0, 8'h80, 8'h00, 8'h80, 1'b0},
    '{1'b0, 1'b1, 3'd6, 8'h03, 8'h00, 8'hC0, 1'b0},
    '{1'b0, 1'b1, 3'd6, 8'h04, 8'h00, 8'hFF, 1'b1},
    '{1'b1, 1'b0, 3'd6, 8'hFF, 8'h00, 8'hC0, 1'b0},
    '{1'b1, 1'b1, 3'd6, 8'h02, 8'h00, 8'h7F, 1'b1},
    '{1'b0, 1'b0, 3'd7, 8'h81, 8'h3C, 8'h3C, 1'b0},
    '{1'b1, 1'b0, 3'd1, 8'hC0, 8'h00, 8'h80, 1'b0}
  };

  // Reference: arithmetic value of the operand times 2^shift, then a range test.
  function automatic void ref_model(input logic sg, input logic sat, input int sh,
                                    input logic [7:0] i, input logic [7:0] e,
                                    output logic [7:0] o, output logic f);
    int full;
    int sv;
    if (sh > SM) begin
      o = e;
      f = 1'b0;
      return;
    end
    if (!sg) begin
      full = int'(i) * (1 << sh);
      f    = (full > 255);
      o    = 8'(full);
    end else begin
      sv   = int'($signed(i)) * (1 << sh);
      f    = (sv > 127) || (sv < -128);
      o    = 8'(sv);
    end
    if (sat && f) begin
      if (!sg)       o = 8'hFF;
      else if (i[7]) o = 8'h80;
      else           o = 8'h7F;
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sg, input logic sat,
                       input logic [2:0] sh, input logic [7:0] i, input logic [7:0] e);
    bus.in_valid  = v;
    bus.is_signed = sg;
    bus.saturate  = sat;
    bus.shift     = sh;
    bus.in        = i;
    bus.ex        = e;
    ref_model(sg, sat, int'(sh), i, e, cur_o, cur_f);
  endtask

  task automatic drive_rand(input logic v);
    drive(v, 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic tick(input string tag);
    logic adv;
    @(posedge clk);
    adv = enable && !srst;
    if (srst) begin
      for (int k = 0; k < LAT; k++) begin
        m_v[k] = 1'b0;
        m_o[k] = 8'h00;
        m_f[k] = 1'b0;
      end
    end else if (enable) begin
      for (int k = LAT - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1];
        m_o[k] = m_o[k-1];
        m_f[k] = m_f[k-1];
      end
      m_v[0] = bus.in_valid;
      m_o[0] = cur_o;
      m_f[0] = cur_f;
    end
    #1;
    if (adv && bus.out_valid === 1'b1) n_emit++;
    chk({tag, " out_valid"}, {7'b0, bus.out_valid}, {7'b0, m_v[LAT-1]});
    if (m_v[LAT-1]) begin
      chk({tag, " out"}, bus.out, m_o[LAT-1]);
      chk({tag, " overflow"}, {7'b0, bus.overflow}, {7'b0, m_f[LAT-1]});
    end
  endtask

  initial begin
    for (int k = 0; k < LAT; k++) begin
      m_v[k] = 1'b0;
      m_o[k] = 8'h00;
      m_f[k] = 1'b0;
    end
    srst   = 1'b1;
    enable = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);

    // Reset state
    for (int n = 0; n < 3; n++) tick("reset");
    chk("reset out", bus.out, 8'h00);
    chk("reset overflow", {7'b0, bus.overflow}, 8'h00);
    srst = 1'b0;

    // Directed vectors streamed back to back
    for (int n = 0; n < 15; n++) begin
      drive(1'b1, dir[n].sg, dir[n].sat, dir[n].sh, dir[n].i, dir[n].e);
      cur_o = dir[n].eo;
      cur_f = dir[n].ef;
      tick("directed");
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    for (int n = 0; n < LAT + 1; n++) tick("drain");

    // Stall: 8 back-to-back samples, enable low for 2 cycles mid-stream
    n_emit = 0;
    for (int n = 0; n < 8; n++) begin
      if (n == 5) begin
        enable = 1'b0;
        for (int s = 0; s < 2; s++) begin
          drive_rand(1'($urandom));
          tick("stall");
        end
        enable = 1'b1;
      end
      drive_rand(1'b1);
      tick("stream");
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    for (int n = 0; n < LAT + 2; n++) tick("stream drain");
    chk("stall emitted count", 8'(n_emit), 8'd8);

    // Reset with 3 samples in flight, then one new sample
    for (int n = 0; n < 3; n++) begin
      drive_rand(1'b1);
      tick("pre reset");
    end
    srst = 1'b1;
    drive_rand(1'b1);
    tick("mid reset");
    srst   = 1'b0;
    n_emit = 0;
    drive(1'b1, 1'b0, 1'b0, 3'd1, 8'h11, 8'h00);
    tick("post reset entry");
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    for (int n = 0; n < 3; n++) tick("post reset wait");
    chk("post reset early", 8'(n_emit), 8'd0);
    tick("post reset emerge");
    chk("post reset emerge valid", {7'b0, bus.out_valid}, 8'd1);
    chk("post reset emerge out", bus.out, 8'h22);
    for (int n = 0; n < 3; n++) tick("post reset tail");
    chk("post reset count", 8'(n_emit), 8'd1);

    // Randomized traffic with occasional stalls and resets
    for (int n = 0; n < 400; n++) begin
      srst   = ($urandom_range(0, 63) == 0);
      enable = ($urandom_range(0, 99) < 85);
      drive_rand(1'($urandom));
      tick("random");
    end
    srst   = 1'b0;
    enable = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    for (int n = 0; n < LAT + 1; n++) tick("final drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_left_sat.md
BARREL_LEFT_SAT -- requirements
Module: barrel_left_sat

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 64: data word width.
REQ-002 The block SHALL have parameter SHIFT_MAX, default 46: largest legal left shift; legal range 1 to WIDTH-1.
REQ-003 The block SHALL have parameter SHIFT_WIDTH, default $clog2(SHIFT_MAX+2): shift port width; a value below $clog2(SHIFT_MAX+2) SHALL print an error and call $finish at elaboration.
REQ-004 The block SHALL have parameter IS_REG_IN, default 1: 1 = register inputs, 0 = combinational input path.

Interface
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 srst  in  1  reset; synchronous, active-high.
REQ-007 enable  in  1  global advance; low = entire pipeline frozen.
REQ-008 in_valid  in  1  qualifies the input sample on this cycle.
REQ-009 is_signed  in  1  1 = two's-complement operand, 0 = unsigned operand.
REQ-010 saturate  in  1  1 = clamp the result on overflow.
REQ-011 shift  in  SHIFT_WIDTH  left shift amount.
REQ-012 in  in  WIDTH  operand.
REQ-013 ex  in  WIDTH  substitute result, used when shift > SHIFT_MAX.
REQ-014 out_valid  out  1  qualifies out and overflow.
REQ-015 out  out  WIDTH  shifted or saturated result.
REQ-016 overflow  out  1  result not representable in WIDTH bits.

Function
REQ-017 The datapath SHALL be logarithmic: stage k (k = 0..SHIFT_WIDTH-1) shifts left by 2^k when shift bit k is 1, zero-fills, and is followed by a register.
REQ-018 Every sample SHALL carry its valid, is_signed, saturate, ex, out-of-range flag, original sign bit and sticky overflow bit alongside the data through each stage.
REQ-019 Latency SHALL be IS_REG_IN + SHIFT_WIDTH + 1 enable-high cycles from input to out; the final +1 is the saturation/output register.
REQ-020 Throughput SHALL be one sample per enable-high cycle, with no bubbles or stalls generated internally.
REQ-021 While enable is 0, every register SHALL hold its value, including all valids; sample order SHALL be preserved.
REQ-022 Unsigned operands: the sticky overflow bit SHALL be set when any 1 bit is shifted out of position WIDTH-1.
REQ-023 Signed operands: the sticky overflow bit SHALL be set when any shifted-out bit differs from the original sign bit, or the final MSB differs from the original sign bit.
REQ-024 A shift in the range 0..SHIFT_MAX SHALL produce out = (in << shift) truncated to WIDTH bits, unless saturation applies.
REQ-025 Saturation SHALL apply when saturate = 1 and overflow = 1:
- unsigned: out = all ones.
- signed, non-negative input: out = 0x7F..F.
- signed, negative input: out = 0x80..0.
REQ-026 overflow SHALL report the raw overflow condition regardless of the saturate input.
REQ-027 A shift > SHIFT_MAX SHALL produce out = ex and overflow = 0, and saturation SHALL NOT apply.
REQ-028 A shift of 0 SHALL produce out = in and overflow = 0.
REQ-029 Samples entered with in_valid = 0 SHALL propagate with out_valid = 0; out and overflow are don't-care on those cycles.

Reset
REQ-030 While srst = 1 on a clock edge, all pipeline valids, out_valid, out and overflow SHALL clear to 0 on that edge.
REQ-031 srst SHALL take priority over enable.
REQ-032 Samples in flight at reset SHALL be discarded and never emerge.
REQ-033 After reset, no out_valid SHALL assert until a full latency after the first post-reset valid input.
REQ-034 Data registers other than the output register need not be reset.

Verification
All scenarios use WIDTH=8, SHIFT_MAX=6, SHIFT_WIDTH=3, IS_REG_IN=1, so latency = 5.
REQ-035 Unsigned, in=0x0F, shift=3, sat=0 -> after 5 cycles: out_valid=1, out=0x78, overflow=0.
REQ-036 Unsigned, in=0x0F, shift=5:
- sat=0 -> out=0xE0, overflow=1.
- sat=1 -> out=0xFF, overflow=1.
REQ-037 Signed cases:
- in=0xF0, shift=3 -> out=0x80, overflow=0.
- in=0x20, shift=2, sat=1 -> out=0x7F, overflow=1.
- in=0xC0, shift=2, sat=1 -> out=0x80, overflow=1.
REQ-038 shift=7, ex=0xA5, in=0xFF, sat=1 -> out=0xA5, overflow=0.
REQ-039 Stall: 8 back-to-back valid samples, enable low for 2 cycles mid-stream -> out and out_valid hold during the stall, all 8 results appear in order, none lost or duplicated.
REQ-040 Reset mid-stream: srst pulsed 1 cycle with 3 samples in flight -> out_valid=0 from the next edge, none of the 3 samples ever appear, and a new sample emerges exactly 5 cycles after entry.
